// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline stage chain and the hazard/sequencing
// controller. The pipeline (master) reports the register usage of the ID,
// EX and MEM instructions; the controller (slave) returns the per-stage
// hold / bubble / flush commands.
//
// There is no valid/ready pair. Every field is level-sensitive and is
// evaluated each cycle. A stage register advances on a rising edge only when
// its freeze input is low in the cycle that edge ends.
interface pipe_hazard_ctrl_if;
  // ID-stage operands
  logic [4:0]  id_src1;
  logic [4:0]  id_src2;
  logic        id_two_src;
  // EX-stage producer
  logic [4:0]  exe_dst;
  logic        exe_wb_en;
  logic        exe_mem_read;
  // MEM-stage producer and its memory operation
  logic [4:0]  mem_dst;
  logic        mem_wb_en;
  logic        mem_stage_rd;
  logic        mem_stage_wr;
  // branch resolved in EX
  logic        branch_taken;
  // controller commands
  logic        pc_freeze;
  logic        if_id_freeze;
  logic        id_ex_bubble;
  logic        flush;
  logic        pipe_freeze;
  logic        sram_req;
  logic        mem_done;
  logic [15:0] stall_count;

  modport master (
    output id_src1, id_src2, id_two_src, exe_dst, exe_wb_en, exe_mem_read,
           mem_dst, mem_wb_en, mem_stage_rd, mem_stage_wr, branch_taken,
    input  pc_freeze, if_id_freeze, id_ex_bubble, flush, pipe_freeze,
           sram_req, mem_done, stall_count
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_dst, exe_wb_en, exe_mem_read,
           mem_dst, mem_wb_en, mem_stage_rd, mem_stage_wr, branch_taken,
    output pc_freeze, if_id_freeze, id_ex_bubble, flush, pipe_freeze,
           sram_req, mem_done, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core. It merges the ID/EX
// data-hazard check, taken branches from EX and a wait-state FSM for the
// multi-cycle data SRAM into freeze/bubble/flush commands for the stage
// registers. It also keeps a saturating count of PC-stall cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_LATENCY = 4,    // SRAM cycles per access, 1..15
  parameter bit          FORWARD_EN  = 1'b0  // 1: forwarding unit present
) (
  input  logic               clk,
  input  logic               rst,           // asynchronous, active-low
  pipe_hazard_ctrl_if.slave  bus,
  output logic [1:0]         o_dbg_state    // memory FSM state, for checkers
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  mem_state_e  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_stall_count;

  logic w_req;
  logic w_match_exe;
  logic w_match_mem;
  logic w_hazard;
  logic w_freeze;
  logic w_pc_freeze;
  logic w_if_id_freeze;
  logic w_bubble;
  logic w_flush;

  assign w_req = bus.mem_stage_rd | bus.mem_stage_wr;

  // A non-zero destination matches src1, or src2 when the ID instruction
  // reads it. Requiring dst != 0 also keeps register 0 from ever matching.
  assign w_match_exe = (bus.exe_dst != 5'd0) &&
                       ((bus.id_src1 == bus.exe_dst) ||
                        (bus.id_two_src && (bus.id_src2 == bus.exe_dst)));
  assign w_match_mem = (bus.mem_dst != 5'd0) &&
                       ((bus.id_src1 == bus.mem_dst) ||
                        (bus.id_two_src && (bus.id_src2 == bus.mem_dst)));

  // With forwarding, only a load in EX cannot be bypassed in time.
  // Without forwarding, any pending write in EX or MEM stalls.
  assign w_hazard = FORWARD_EN ? (bus.exe_mem_read && w_match_exe)
                               : ((bus.exe_wb_en && w_match_exe) ||
                                  (bus.mem_wb_en && w_match_mem));

  // The pipeline is frozen from the first cycle a request is seen until the
  // access finishes. DONE is never frozen, so the MEM instruction leaves on
  // the edge that ends DONE.
  assign w_freeze = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY);

  // Memory wait-state sequencer. A request that is still present in DONE
  // belongs to the finishing instruction and is deliberately ignored there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (MEM_LATENCY == 32'd1) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= 4'd1;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Priority resolution: memory freeze, then branch flush, then hazard
  // bubble. Everything is forced low while reset is asserted.
  always_comb begin
    w_pc_freeze    = 1'b0;
    w_if_id_freeze = 1'b0;
    w_bubble       = 1'b0;
    w_flush        = 1'b0;
    if (rst) begin
      if (w_freeze) begin
        w_pc_freeze    = 1'b1;
        w_if_id_freeze = 1'b1;
      end else if (bus.branch_taken) begin
        w_flush = 1'b1;
      end else if (w_hazard) begin
        w_pc_freeze    = 1'b1;
        w_if_id_freeze = 1'b1;
        w_bubble       = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= 16'd0;
    end else if (w_pc_freeze && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign bus.pc_freeze    = w_pc_freeze;
  assign bus.if_id_freeze = w_if_id_freeze;
  assign bus.id_ex_bubble = w_bubble;
  assign bus.flush        = w_flush;
  assign bus.pipe_freeze  = rst & w_freeze;
  assign bus.sram_req     = rst & w_freeze;
  assign bus.mem_done     = rst & (r_state == ST_DONE);
  assign bus.stall_count  = r_stall_count;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Three instances share one stimulus:
//   dut_a: latency 4, forwarding present
//   dut_n: latency 4, no forwarding
//   dut_l: latency 1, forwarding present
// The observed outputs are packed as
// {pc_freeze, if_id_freeze, id_ex_bubble, flush, pipe_freeze, sram_req, mem_done}.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_STALL  = 7'b1110000;
  localparam logic [6:0] O_FLUSH  = 7'b0001000;
  localparam logic [6:0] O_FROZEN = 7'b1100110;
  localparam logic [6:0] O_DONE   = 7'b0000001;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [4:0] t_src1, t_src2, t_exe_dst, t_mem_dst;
  logic       t_two_src, t_exe_wb_en, t_exe_mem_read, t_mem_wb_en;
  logic       t_mem_rd, t_mem_wr, t_branch;

  pipe_hazard_ctrl_if bus_a();
  pipe_hazard_ctrl_if bus_n();
  pipe_hazard_ctrl_if bus_l();

  assign bus_a.id_src1 = t_src1;        assign bus_n.id_src1 = t_src1;        assign bus_l.id_src1 = t_src1;
  assign bus_a.id_src2 = t_src2;        assign bus_n.id_src2 = t_src2;        assign bus_l.id_src2 = t_src2;
  assign bus_a.id_two_src = t_two_src;  assign bus_n.id_two_src = t_two_src;  assign bus_l.id_two_src = t_two_src;
  assign bus_a.exe_dst = t_exe_dst;     assign bus_n.exe_dst = t_exe_dst;     assign bus_l.exe_dst = t_exe_dst;
  assign bus_a.exe_wb_en = t_exe_wb_en; assign bus_n.exe_wb_en = t_exe_wb_en; assign bus_l.exe_wb_en = t_exe_wb_en;
  assign bus_a.exe_mem_read = t_exe_mem_read;
  assign bus_n.exe_mem_read = t_exe_mem_read;
  assign bus_l.exe_mem_read = t_exe_mem_read;
  assign bus_a.mem_dst = t_mem_dst;     assign bus_n.mem_dst = t_mem_dst;     assign bus_l.mem_dst = t_mem_dst;
  assign bus_a.mem_wb_en = t_mem_wb_en; assign bus_n.mem_wb_en = t_mem_wb_en; assign bus_l.mem_wb_en = t_mem_wb_en;
  assign bus_a.mem_stage_rd = t_mem_rd; assign bus_n.mem_stage_rd = t_mem_rd; assign bus_l.mem_stage_rd = t_mem_rd;
  assign bus_a.mem_stage_wr = t_mem_wr; assign bus_n.mem_stage_wr = t_mem_wr; assign bus_l.mem_stage_wr = t_mem_wr;
  assign bus_a.branch_taken = t_branch; assign bus_n.branch_taken = t_branch; assign bus_l.branch_taken = t_branch;

  logic [1:0] dbg_a, dbg_n, dbg_l;

  pipe_hazard_ctrl #(.MEM_LATENCY(4), .FORWARD_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .o_dbg_state(dbg_a));
  pipe_hazard_ctrl #(.MEM_LATENCY(4), .FORWARD_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n.slave), .o_dbg_state(dbg_n));
  pipe_hazard_ctrl #(.MEM_LATENCY(1), .FORWARD_EN(1'b1)) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l.slave), .o_dbg_state(dbg_l));

  logic [6:0] obs_a, obs_n, obs_l;
  assign obs_a = {bus_a.pc_freeze, bus_a.if_id_freeze, bus_a.id_ex_bubble, bus_a.flush,
                  bus_a.pipe_freeze, bus_a.sram_req, bus_a.mem_done};
  assign obs_n = {bus_n.pc_freeze, bus_n.if_id_freeze, bus_n.id_ex_bubble, bus_n.flush,
                  bus_n.pipe_freeze, bus_n.sram_req, bus_n.mem_done};
  assign obs_l = {bus_l.pc_freeze, bus_l.if_id_freeze, bus_l.id_ex_bubble, bus_l.flush,
                  bus_l.pipe_freeze, bus_l.sram_req, bus_l.mem_done};

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];    // dut_a
  logic [6:0] exp_n_q[$];  // dut_n
  logic [6:0] exp_l_q[$];  // dut_l
  int n_checks;
  int n_fail;

  // ---------------- driver tasks ----------------
  task automatic drv_hazard(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                            input logic [4:0] ed, input logic ewb, input logic emr,
                            input logic [4:0] md, input logic mwb);
    t_src1 = s1; t_src2 = s2; t_two_src = two;
    t_exe_dst = ed; t_exe_wb_en = ewb; t_exe_mem_read = emr;
    t_mem_dst = md; t_mem_wb_en = mwb;
  endtask

  task automatic drv_mem(input logic rd, input logic wr, input logic br);
    t_mem_rd = rd; t_mem_wr = wr; t_branch = br;
  endtask

  task automatic clear_inputs();
    drv_hazard(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    drv_mem(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [6:0] e;
    rst = 1'b0;
    drv_hazard(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    drv_mem(1'b1, 1'b0, 1'b1);
    #3;
    exp_q.push_back(O_IDLE);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_a !== e) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs_a, e);
    end
    n_checks++;
    if (bus_a.stall_count !== 16'd0 || dbg_a !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: stall_count %h state %0d expected 0/0", bus_a.stall_count, dbg_a);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_q.push_back(O_IDLE);
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e || bus_a.stall_count !== 16'd0) begin
        n_fail++; $display("FAIL post_reset_idle[%0d]: got %b cnt %h expected %b cnt 0", k, obs_a, bus_a.stall_count, e);
      end
    end
  endtask

  typedef struct packed {
    logic [4:0] s1;
    logic [4:0] s2;
    logic       two;
    logic [4:0] ed;
    logic       ewb;
    logic       emr;
    logic [4:0] md;
    logic       mwb;
    logic       br;
    logic [6:0] exp_fwd;
    logic [6:0] exp_nofwd;
  } hz_vec_t;

  task automatic test_hazard();
    hz_vec_t tbl [12];
    logic [6:0] e;
    tbl[0]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_STALL, O_STALL}; // load-use
    tbl[1]  = '{5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_IDLE,  O_IDLE};  // dst r0
    tbl[2]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, O_IDLE,  O_STALL}; // ALU in EX
    tbl[3]  = '{5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, O_IDLE,  O_STALL}; // src2 vs MEM
    tbl[4]  = '{5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, O_IDLE,  O_IDLE};  // src2 unused
    tbl[5]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_IDLE,  O_IDLE};  // r0 vs r0
    tbl[6]  = '{5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_STALL, O_STALL}; // load-use src2
    tbl[7]  = '{5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_IDLE,  O_IDLE};  // src2 unused
    tbl[8]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, O_FLUSH, O_FLUSH}; // branch wins
    tbl[9]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, O_FLUSH, O_FLUSH}; // branch only
    tbl[10] = '{5'd6, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, O_STALL, O_IDLE};  // read, no wb
    tbl[11] = '{5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, O_IDLE,  O_STALL}; // MEM match
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drv_hazard(tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].ed, tbl[i].ewb, tbl[i].emr,
                 tbl[i].md, tbl[i].mwb);
      drv_mem(1'b0, 1'b0, tbl[i].br);
      exp_q.push_back(tbl[i].exp_fwd);
      exp_n_q.push_back(tbl[i].exp_nofwd);
      exp_l_q.push_back(tbl[i].exp_fwd);
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL hazard_fwd[%0d]: got %b expected %b", i, obs_a, e);
      end
      e = exp_n_q.pop_front();
      n_checks++;
      if (obs_n !== e) begin
        n_fail++; $display("FAIL hazard_nofwd[%0d]: got %b expected %b", i, obs_n, e);
      end
      e = exp_l_q.pop_front();
      n_checks++;
      if (obs_l !== e) begin
        n_fail++; $display("FAIL hazard_fwd_l1[%0d]: got %b expected %b", i, obs_l, e);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Held request: latency L gives L frozen cycles, one DONE cycle, repeat.
  task automatic test_sram_access();
    logic [6:0] e;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      drv_mem(($urandom_range(0, 1) == 0), 1'b0, 1'b0);
      if (!t_mem_rd) t_mem_wr = 1'b1;
      exp_q.push_back((((k - 1) % 5) < 4) ? O_FROZEN : O_DONE);
      exp_l_q.push_back((((k - 1) % 2) < 1) ? O_FROZEN : O_DONE);
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL sram_l4 cycle %0d: got %b expected %b", k, obs_a, e);
      end
      e = exp_l_q.pop_front();
      n_checks++;
      if (obs_l !== e) begin
        n_fail++; $display("FAIL sram_l1 cycle %0d: got %b expected %b", k, obs_l, e);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Branch raised while BUSY is held back until the DONE cycle.
  task automatic test_freeze_over_branch();
    logic [6:0] e;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) drv_mem(1'b1, 1'b0, (k >= 2));
      else clear_inputs();
      exp_q.push_back((k <= 4) ? O_FROZEN : ((k == 5) ? 7'b0001001 : O_IDLE));
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL freeze_over_branch cycle %0d: got %b expected %b", k, obs_a, e);
      end
    end
  endtask

  // Hazard present during a freeze: no bubble while frozen, bubble at DONE.
  task automatic test_hazard_across_freeze();
    logic [6:0] e;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drv_hazard(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
      drv_mem(1'b0, 1'b1, 1'b0);
      exp_q.push_back((k <= 4) ? O_FROZEN : 7'b1110001);
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL hazard_across_freeze cycle %0d: got %b expected %b", k, obs_a, e);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Reset in BUSY clears everything at once; a held request restarts cleanly.
  task automatic test_reset_mid_access();
    logic [6:0] e;
    do_reset();
    @(negedge clk);
    drv_mem(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    drv_hazard(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    t_branch = 1'b1;
    exp_q.push_back(O_IDLE);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (obs_a !== e || bus_a.stall_count !== 16'd0 || dbg_a !== 2'd0) begin
      n_fail++; $display("FAIL reset_mid_access: got %b cnt %h state %0d expected %b cnt 0 state 0",
                         obs_a, bus_a.stall_count, dbg_a, e);
    end
    @(negedge clk);
    rst = 1'b1;
    drv_hazard(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    t_branch = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      exp_q.push_back((k <= 4) ? O_FROZEN : O_DONE);
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e || bus_a.stall_count !== 16'(k - 1)) begin
        n_fail++; $display("FAIL restart_after_reset cycle %0d: got %b cnt %0d expected %b cnt %0d",
                           k, obs_a, bus_a.stall_count, e, k - 1);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_stall_counter();
    do_reset();
    @(negedge clk);
    drv_hazard(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.stall_count !== 16'd100) begin
      n_fail++; $display("FAIL stall_count_100: got %0d expected 100", bus_a.stall_count);
    end
    repeat (69900) @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.stall_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL stall_count_sat: got %h expected ffff", bus_a.stall_count);
    end
    n_checks++;
    if (bus_n.stall_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL stall_count_sat_nofwd: got %h expected ffff", bus_n.stall_count);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear_inputs();
    test_reset();
    test_hazard();
    test_sram_access();
    test_freeze_over_branch();
    test_hazard_across_freeze();
    test_reset_mid_access();
    test_stall_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
